// File: rtl/ecc_pkg.sv
// Shared constants for the 32-bit SEC-DED syndrome pipeline: check width,
// bit-position width and the data-column table of the Hamming code.
// Ports: none (package only).
package ecc_pkg;

  localparam int CHK_W      = 7;   // check / syndrome width
  localparam int POS_W      = 6;   // flipped-bit index width (covers 0..38)
  localparam int MAX_DATA_W = 32;  // widest data word the column table covers

  // Column of the parity-check matrix for data bit i. Every column has
  // weight 3, so no data column can alias a check-bit column (weight 1)
  // and any double error yields an even-weight, non-matching syndrome.
  function automatic logic [CHK_W-1:0] col(input int i);
    logic [CHK_W-1:0] c;
    c = '0;
    case (i)
      0:  c = 7'd97;   1:  c = 7'd81;   2:  c = 7'd25;   3:  c = 7'd69;
      4:  c = 7'd67;   5:  c = 7'd49;   6:  c = 7'd41;   7:  c = 7'd19;
      8:  c = 7'd98;   9:  c = 7'd82;   10: c = 7'd74;   11: c = 7'd70;
      12: c = 7'd50;   13: c = 7'd42;   14: c = 7'd35;   15: c = 7'd26;
      16: c = 7'd44;   17: c = 7'd100;  18: c = 7'd38;   19: c = 7'd37;
      20: c = 7'd52;   21: c = 7'd7;    22: c = 7'd11;   23: c = 7'd13;
      24: c = 7'd14;   25: c = 7'd21;   26: c = 7'd22;   27: c = 7'd28;
      28: c = 7'd56;   29: c = 7'd73;   30: c = 7'd76;   31: c = 7'd84;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ecc_synd_dec.sv
// Combinational syndrome decoder: maps a 7-bit syndrome to correctable /
// uncorrectable flags and the index of the flipped bit.
// Ports: synd_i in; ce_o, ue_o, pos_o out (pos_o = 0 unless ce_o).
module ecc_synd_dec
  import ecc_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [CHK_W-1:0] synd_i,
  output logic             ce_o,
  output logic             ue_o,
  output logic [POS_W-1:0] pos_o
);

  always_comb begin
    ce_o  = 1'b0;
    ue_o  = 1'b0;
    pos_o = '0;
    if (synd_i != '0) begin
      for (int i = 0; i < DATA_W; i++) begin
        if (synd_i == col(i)) begin
          ce_o  = 1'b1;
          pos_o = POS_W'(i);
        end
      end
      // Check-bit k has a one-hot column; those sit above the data indices.
      for (int k = 0; k < CHK_W; k++) begin
        if (synd_i == CHK_W'(1 << k)) begin
          ce_o  = 1'b1;
          pos_o = POS_W'(DATA_W + k);
        end
      end
      // Nonzero but unmatched: even weight (double error) or stray odd weight.
      ue_o = !ce_o;
    end
  end

endmodule

// File: rtl/ecc_synd_pipe.sv
// Two-stage SEC-DED check pipeline: S1 registers data + syndrome, S2 registers
// the corrected word, flags and bit index; saturating CE/UE counters.
// Ports: clk/rst; in_valid/in_ready/in_data/in_check; out_valid/out_ready/
// out_data/out_synd/out_ce/out_ue/out_pos; cnt_clr, cnt_ce, cnt_ue.
module ecc_synd_pipe
  import ecc_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CHK_W-1:0]  in_check,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CHK_W-1:0]  out_synd,
  output logic              out_ce,
  output logic              out_ue,
  output logic [POS_W-1:0]  out_pos,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  cnt_ce,
  output logic [CNT_W-1:0]  cnt_ue
);

  // Stage 1 state
  logic              s1_vld_q, s1_vld_d;
  logic [DATA_W-1:0] s1_data_q, s1_data_d;
  logic [CHK_W-1:0]  s1_synd_q, s1_synd_d;

  // Stage 2 state (drives the outputs directly)
  logic              s2_vld_q, s2_vld_d;
  logic [DATA_W-1:0] s2_data_q, s2_data_d;
  logic [CHK_W-1:0]  s2_synd_q, s2_synd_d;
  logic              s2_ce_q, s2_ce_d;
  logic              s2_ue_q, s2_ue_d;
  logic [POS_W-1:0]  s2_pos_q, s2_pos_d;

  logic [CNT_W-1:0]  cnt_ce_q, cnt_ce_d;
  logic [CNT_W-1:0]  cnt_ue_q, cnt_ue_d;

  logic              s2_load;
  logic              in_hs;
  logic              out_hs;
  logic [CHK_W-1:0]  in_synd;
  logic              dec_ce;
  logic              dec_ue;
  logic [POS_W-1:0]  dec_pos;
  logic [DATA_W-1:0] flip;

  assign s2_load  = !s2_vld_q || out_ready;
  assign in_ready = !s1_vld_q || s2_load;
  assign in_hs    = in_valid && in_ready;
  assign out_hs   = s2_vld_q && out_ready;

  // Syndrome of the incoming word
  always_comb begin
    in_synd = in_check;
    for (int i = 0; i < DATA_W; i++) begin
      if (in_data[i]) in_synd = in_synd ^ col(i);
    end
  end

  ecc_synd_dec #(.DATA_W(DATA_W)) u_dec (
    .synd_i (s1_synd_q),
    .ce_o   (dec_ce),
    .ue_o   (dec_ue),
    .pos_o  (dec_pos)
  );

  // Only a data-bit position produces a flip; check-bit positions never
  // compare equal to an index below DATA_W.
  always_comb begin
    flip = '0;
    for (int i = 0; i < DATA_W; i++) begin
      flip[i] = dec_ce && (dec_pos == POS_W'(i));
    end
  end

  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_data_d = s1_data_q;
    s1_synd_d = s1_synd_q;
    s2_vld_d  = s2_vld_q;
    s2_data_d = s2_data_q;
    s2_synd_d = s2_synd_q;
    s2_ce_d   = s2_ce_q;
    s2_ue_d   = s2_ue_q;
    s2_pos_d  = s2_pos_q;
    cnt_ce_d  = cnt_ce_q;
    cnt_ue_d  = cnt_ue_q;

    if (in_hs) begin
      s1_vld_d  = 1'b1;
      s1_data_d = in_data;
      s1_synd_d = in_synd;
    end else if (s2_load) begin
      s1_vld_d  = 1'b0;
    end

    if (s2_load) begin
      s2_vld_d = s1_vld_q;
      // Payload is only replaced by a real word, so a bubble leaves it as-is.
      if (s1_vld_q) begin
        s2_data_d = s1_data_q ^ flip;
        s2_synd_d = s1_synd_q;
        s2_ce_d   = dec_ce;
        s2_ue_d   = dec_ue;
        s2_pos_d  = dec_pos;
      end
    end

    if (cnt_clr) begin
      cnt_ce_d = '0;
      cnt_ue_d = '0;
    end else if (out_hs) begin
      if (s2_ce_q && (cnt_ce_q != '1)) cnt_ce_d = cnt_ce_q + 1'b1;
      if (s2_ue_q && (cnt_ue_q != '1)) cnt_ue_d = cnt_ue_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      s1_data_q <= '0;
      s1_synd_q <= '0;
      s2_vld_q  <= 1'b0;
      s2_data_q <= '0;
      s2_synd_q <= '0;
      s2_ce_q   <= 1'b0;
      s2_ue_q   <= 1'b0;
      s2_pos_q  <= '0;
      cnt_ce_q  <= '0;
      cnt_ue_q  <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_data_q <= s1_data_d;
      s1_synd_q <= s1_synd_d;
      s2_vld_q  <= s2_vld_d;
      s2_data_q <= s2_data_d;
      s2_synd_q <= s2_synd_d;
      s2_ce_q   <= s2_ce_d;
      s2_ue_q   <= s2_ue_d;
      s2_pos_q  <= s2_pos_d;
      cnt_ce_q  <= cnt_ce_d;
      cnt_ue_q  <= cnt_ue_d;
    end
  end

  assign out_valid = s2_vld_q;
  assign out_data  = s2_data_q;
  assign out_synd  = s2_synd_q;
  assign out_ce    = s2_ce_q;
  assign out_ue    = s2_ue_q;
  assign out_pos   = s2_pos_q;
  assign cnt_ce    = cnt_ce_q;
  assign cnt_ue    = cnt_ue_q;

endmodule

// File: tb/tb_ecc_synd_pipe.sv
// Testbench for ecc_synd_pipe: directed literal vectors, a backpressure stream,
// counter saturation/clear, then randomized traffic against a queue model.
module tb_ecc_synd_pipe;

  localparam int DW = 32;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [6:0]    in_check;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [6:0]    out_synd;
  logic          out_ce;
  logic          out_ue;
  logic [5:0]    out_pos;
  logic          cnt_clr;
  logic [CW-1:0] cnt_ce;
  logic [CW-1:0] cnt_ue;

  always #5 clk = ~clk;

  ecc_synd_pipe #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_check(in_check),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_synd(out_synd), .out_ce(out_ce), .out_ue(out_ue), .out_pos(out_pos),
    .cnt_clr(cnt_clr), .cnt_ce(cnt_ce), .cnt_ue(cnt_ue)
  );

  logic [6:0] colt [32] = '{7'd97, 7'd81, 7'd25, 7'd69, 7'd67, 7'd49, 7'd41, 7'd19,
                            7'd98, 7'd82, 7'd74, 7'd70, 7'd50, 7'd42, 7'd35, 7'd26,
                            7'd44, 7'd100, 7'd38, 7'd37, 7'd52, 7'd7, 7'd11, 7'd13,
                            7'd14, 7'd21, 7'd22, 7'd28, 7'd56, 7'd73, 7'd76, 7'd84};

  typedef struct {
    logic [31:0] data;
    logic [6:0]  synd;
    logic        ce;
    logic        ue;
    logic [5:0]  pos;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   m_cce    = 0;
  int   m_cue    = 0;
  int   cmax     = (1 << CW) - 1;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] good_check(input logic [31:0] d);
    logic [6:0] s;
    s = '0;
    for (int i = 0; i < DW; i++) if (d[i]) s = s ^ colt[i];
    return s;
  endfunction

  // Reference decode straight from the code's definition
  function automatic exp_t model(input logic [31:0] d, input logic [6:0] c, input int acc);
    exp_t e;
    e.synd = c ^ good_check(d);
    e.data = d;
    e.ce   = 1'b0;
    e.ue   = 1'b0;
    e.pos  = '0;
    e.acc  = acc;
    if (e.synd != 0) begin
      for (int i = 0; i < DW; i++)
        if (colt[i] == e.synd) begin
          e.ce = 1'b1; e.pos = 6'(i); e.data[i] = ~d[i];
        end
      for (int k = 0; k < 7; k++)
        if (e.synd == 7'(1 << k)) begin
          e.ce = 1'b1; e.pos = 6'(DW + k);
        end
      e.ue = !e.ce;
    end
    return e;
  endfunction

  // Compare process: outputs sampled mid-cycle, model advanced with the
  // handshakes that the coming rising edge will perform.
  always @(negedge clk) begin
    logic exp_vld;
    logic exp_rdy;
    cyc++;
    if (rst) begin
      q.delete();
      m_cce = 0;
      m_cue = 0;
    end else begin
      exp_vld = (q.size() > 0) && (cyc - q[0].acc >= 2);
      exp_rdy = !(q.size() == 2 && !out_ready);
      check("out_valid", out_valid, exp_vld);
      check("in_ready", in_ready, exp_rdy);
      if (exp_vld) begin
        check("out_data", out_data, q[0].data);
        check("out_synd", out_synd, q[0].synd);
        check("out_ce", out_ce, q[0].ce);
        check("out_ue", out_ue, q[0].ue);
        check("out_pos", out_pos, q[0].pos);
        check("ce_ue_excl", out_ce && out_ue, 1'b0);
      end
      check("cnt_ce", cnt_ce, m_cce);
      check("cnt_ue", cnt_ue, m_cue);
      if (cnt_clr) begin
        m_cce = 0;
        m_cue = 0;
      end else if (exp_vld && out_ready) begin
        if (q[0].ce && m_cce < cmax) m_cce++;
        if (q[0].ue && m_cue < cmax) m_cue++;
      end
      if (exp_vld && out_ready) void'(q.pop_front());
      if (in_valid && exp_rdy) q.push_back(model(in_data, in_check, cyc));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One word into an empty pipe with out_ready high; returns 2 edges after
  // the input handshake, when the result must be on the outputs.
  task automatic send1(input logic [31:0] d, input logic [6:0] c);
    in_valid = 1'b1; in_data = d; in_check = c;
    tick();
    in_valid = 1'b0;
    tick();
  endtask

  task automatic rand_word(output logic [31:0] d, output logic [6:0] c);
    int mode;
    int a;
    int b;
    d    = $urandom;
    mode = $urandom_range(0, 4);
    c    = good_check(d);
    a    = $urandom_range(0, 31);
    b    = (a + $urandom_range(1, 31)) % 32;
    case (mode)
      1: d[a] = ~d[a];
      2: c = c ^ 7'(1 << $urandom_range(0, 6));
      3: begin d[a] = ~d[a]; d[b] = ~d[b]; end
      4: c = 7'($urandom);
      default: ;
    endcase
  endtask

  initial begin
    logic [31:0] d;
    logic [6:0]  c;
    int          idx;
    int          seen_stall;
    int          t;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_check = '0;
    out_ready = 1'b1; cnt_clr = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_data", out_data, 0);
    check("rst_out_synd", out_synd, 0);
    check("rst_flags", {out_ce, out_ue, out_pos}, 0);
    check("rst_cnts", {cnt_ce, cnt_ue}, 0);

    send1(32'h0000_0000, 7'h00);
    check("v0_valid", out_valid, 1);
    check("v0_synd", out_synd, 7'h00);
    check("v0_flags", {out_ce, out_ue}, 2'b00);
    check("v0_data", out_data, 32'h0);
    tick();

    send1(32'h0000_0001, 7'h00);
    check("v1_synd", out_synd, 7'h61);
    check("v1_ce_pos", {out_ce, out_ue, out_pos}, {2'b10, 6'd0});
    check("v1_data", out_data, 32'h0);
    tick();

    send1(32'h8000_0000, 7'h00);
    check("v2_synd", out_synd, 7'h54);
    check("v2_ce_pos", {out_ce, out_ue, out_pos}, {2'b10, 6'd31});
    check("v2_data", out_data, 32'h0);
    tick();

    send1(32'h0, 7'h08);
    check("v3_synd", out_synd, 7'h08);
    check("v3_ce_pos", {out_ce, out_ue, out_pos}, {2'b10, 6'd35});
    check("v3_data", out_data, 32'h0);
    tick();

    send1(32'h3, 7'h00);
    check("v4_synd", out_synd, 7'h30);
    check("v4_ue", {out_ce, out_ue, out_pos}, {2'b01, 6'd0});
    check("v4_data", out_data, 32'h3);
    tick();

    send1(32'h0, 7'h58);
    check("v5_synd", out_synd, 7'h58);
    check("v5_ue", {out_ce, out_ue}, 2'b01);
    tick();

    // Counter saturation at 3 (2-bit counter) and clear priority
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 32'(1) << (i * 3); in_check = 7'h00;
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();
    check("sat_cnt_ce", cnt_ce, 2'd3);
    check("sat_cnt_ue", cnt_ue, 2'd0);
    send1(32'h0000_0010, 7'h00);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("clr_over_inc", cnt_ce, 2'd0);

    // Five-word stream with the consumer stalled for stream cycles 2..4
    idx = 0;
    seen_stall = 0;
    t = 0;
    rand_word(d, c);
    while (idx < 5 && t < 40) begin
      out_ready = !(t >= 2 && t <= 4);
      in_valid = 1'b1; in_data = d; in_check = c;
      @(negedge clk);
      if (!in_ready) seen_stall++;
      if (in_ready) begin
        idx++;
        rand_word(d, c);
      end
      tick();
      t++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("stream_accepted", idx, 5);
    check("stream_in_ready_dropped", seen_stall > 0, 1);
    t = 0;
    while (q.size() != 0 && t < 20) begin
      tick();
      t++;
    end
    check("stream_drained", q.size(), 0);

    // Randomized traffic with backpressure, clears and mid-stream resets
    for (int n = 0; n < 4000; n++) begin
      rand_word(d, c);
      in_valid  = ($urandom_range(0, 99) < 70);
      in_data   = d;
      in_check  = c;
      out_ready = ($urandom_range(0, 99) < 65);
      cnt_clr   = ($urandom_range(0, 99) < 3);
      rst       = ($urandom_range(0, 999) < 8);
      tick();
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
    t = 0;
    while (q.size() != 0 && t < 20) begin
      tick();
      t++;
    end
    check("final_drained", q.size(), 0);
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ecc_synd_pipe.md
ECC_SYND_PIPE -- requirements
Module: ecc_synd_pipe

Interface
REQ-001 Parameter DATA_W, default 32, protected data width; legal range 1..32.
REQ-002 Parameter CNT_W, default 16, error-counter width; legal range 2..32.
REQ-003 Check/syndrome width fixed at 7 bits; reset is synchronous and active-high on one clock.
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  input word present.
REQ-007 in_ready  out  1  block accepts input this cycle.
REQ-008 in_data  in  DATA_W  received data bits.
REQ-009 in_check  in  7  received check bits.
REQ-010 out_valid  out  1  result present.
REQ-011 out_ready  in  1  consumer accepts result this cycle.
REQ-012 out_data  out  DATA_W  corrected data.
REQ-013 out_synd  out  7  raw syndrome of the word.
REQ-014 out_ce  out  1  single-bit error corrected (data or check bit).
REQ-015 out_ue  out  1  uncorrectable error detected.
REQ-016 out_pos  out  6  flipped-bit index: 0..DATA_W-1 data, DATA_W+k check bit k; 0 when out_ce=0.
REQ-017 cnt_clr  in  1  clears both counters.
REQ-018 cnt_ce / cnt_ue  out  CNT_W each  saturating counts of accepted CE / UE results.

Function
REQ-019 Syndrome SHALL be in_check XOR (XOR of COL[i] for every i with in_data[i]=1).
REQ-020 COL[0..20] SHALL be 97,81,25,69,67,49,41,19,98,82,74,70,50,42,35,26,44,100,38,37,52; COL[21..31] SHALL be 7,11,13,14,21,22,28,56,73,76,84; only COL[0..DATA_W-1] used.
REQ-021 Check bit k SHALL have column 2^k (k=0..6).
REQ-022 Syndrome 0: out_ce=0, out_ue=0, out_data=in_data.
REQ-023 Syndrome equal to COL[i], i<DATA_W: out_data = in_data with bit i inverted, out_ce=1, out_pos=i.
REQ-024 Syndrome equal to 2^k: out_data=in_data, out_ce=1, out_pos=DATA_W+k.
REQ-025 Any other nonzero syndrome (even weight or unmatched odd weight): out_ue=1, out_ce=0, out_data=in_data unmodified.
REQ-026 out_ce and out_ue SHALL never both be 1.
REQ-027 Two register stages: S1 holds data+syndrome, S2 holds decoded result; latency exactly 2 cycles from input handshake to out_valid when out_ready=1.
REQ-028 S2 loads when !out_valid or out_ready; S1 advances into S2 under the same condition; in_ready = !S1_valid or S2 loads this cycle.
REQ-029 Throughput one word per cycle with out_ready held high; no word dropped or duplicated under any backpressure; order preserved.
REQ-030 out_* payload SHALL hold stable while out_valid=1 and out_ready=0.
REQ-031 Counters increment only on output handshake (out_valid and out_ready) with the matching flag; saturate at 2^CNT_W-1.
REQ-032 cnt_clr takes priority over a same-cycle increment; counters read 0 the next cycle.

Reset
REQ-033 rst SHALL clear S1/S2 valid, out_valid=0, in_ready=1 the cycle after deassertion, out_data=0, out_synd=0, out_ce=0, out_ue=0, out_pos=0, cnt_ce=0, cnt_ue=0.
REQ-034 rst mid-stream SHALL discard all in-flight words; no partial result emitted and counters not incremented.

Structure
REQ-035 Column table COL, check-bit width constant 7, and out_pos width constant 6 SHALL live in shared package ecc_pkg.
REQ-036 Syndrome-to-location decode (syndrome in; ce, ue, pos out) SHALL be one combinational sub-module ecc_synd_dec.

Verification
REQ-037 in_data=0x00000000, in_check=0x00 -> out_synd=0x00, ce=0, ue=0, out_data=0x00000000 two cycles later.
REQ-038 in_data=0x00000001, in_check=0x00 -> out_synd=0x61, ce=1, pos=0, out_data=0x00000000; in_data=0x80000000 -> synd=0x54, pos=31.
REQ-039 in_data=0x0, in_check=0x08 -> synd=0x08, ce=1, pos=35, out_data=0x0; in_data=0x3, in_check=0 -> synd=0x30, ue=1, out_data=0x3.
REQ-040 in_data=0x0, in_check=0x58 -> synd=0x58 (odd, unmatched), ue=1, ce=0.
REQ-041 Stream 5 words, out_ready low cycles 2-4 -> in_ready drops with S1 and S2 full, all 5 words emitted in order, payload stable during stall.
REQ-042 CNT_W=2, 5 accepted CE words -> cnt_ce saturates at 3; cnt_clr with simultaneous CE handshake -> cnt_ce=0.
